mips_dmem_arbiter: RTL and testbench

MIPS_DMEM_ARBITER -- requirements
Module: mips_dmem_arbiter

---
 rtl/mips_dmem_arbiter_if.sv | 54 +++++
 rtl/mips_dmem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mips_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_dmem_arbiter_if.sv
// rtl/mips_dmem_arbiter_if.sv - CPU and loader/debug request ports plus data memory bus of the dmem arbiter
// d_lock is present only when MIPS_DMEM_ARB_LOCK_EN is defined.
interface mips_dmem_arbiter_if;
  logic        c_req;
  logic        c_we;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic        c_ack;
  logic [31:0] c_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
`ifdef MIPS_DMEM_ARB_LOCK_EN
  logic        d_lock;
`endif

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic        err;

  modport master (
`ifdef MIPS_DMEM_ARB_LOCK_EN
    input  d_lock,
`endif
    input  c_req, c_we, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output err
  );

  modport slave (
`ifdef MIPS_DMEM_ARB_LOCK_EN
    output d_lock,
`endif
    output c_req, c_we, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  err
  );
endinterface

// File: rtl/mips_dmem_arbiter.sv
// rtl/mips_dmem_arbiter.sv - round-robin CPU/debug arbiter for a single-port data memory (IDLE/ACCESS/RESP)
// Optional debug lock with 16-grant fairness escape is enabled by MIPS_DMEM_ARB_LOCK_EN.
module mips_dmem_arbiter (
  input logic                 clk,
  input logic                 rst,
  mips_dmem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // 1 = debug port
  logic        last_q,  last_d;    // port granted most recently, 1 = debug port
  logic [31:0] c_rdata_q, c_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_oor;
  logic [31:0] rdata_val;

  logic        c_elig;
  logic        any_req;
  logic        win_d;

`ifdef MIPS_DMEM_ARB_LOCK_EN
  logic        lock_q, lock_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      c_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      err_q     <= 1'b0;
`ifdef MIPS_DMEM_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_cnt_q <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
`ifdef MIPS_DMEM_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Granted port's live request fields; requesters hold them stable until ack.
  always_comb begin
    if (grant_q) begin
      sel_we    = bus.d_we;
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
    end else begin
      sel_we    = bus.c_we;
      sel_addr  = bus.c_addr;
      sel_wdata = bus.c_wdata;
    end
    sel_oor   = |sel_addr[31:8];
    rdata_val = (sel_we || sel_oor) ? 32'd0 : bus.mem_rdata;
  end

  always_comb begin
`ifdef MIPS_DMEM_ARB_LOCK_EN
    c_elig = bus.c_req & ~lock_q;
`else
    c_elig = bus.c_req;
`endif
    any_req = c_elig | bus.d_req;
    // D wins when alone, or on a tie when C held the previous grant.
    win_d   = bus.d_req & (~c_elig | ~last_q);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;
`ifdef MIPS_DMEM_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_cnt_d = lock_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          grant_d = win_d;
          last_d  = win_d;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (grant_q) begin
          d_rdata_d = rdata_val;
        end else begin
          c_rdata_d = rdata_val;
        end
        err_d = err_q | sel_oor;
      end
      RESP: begin
        state_d = IDLE;
`ifdef MIPS_DMEM_ARB_LOCK_EN
        // The 16th consecutive locked grant drops the lock for one arbitration.
        if (grant_q && bus.d_lock) begin
          if (lock_cnt_q == 4'hF) begin
            lock_d     = 1'b0;
            lock_cnt_d = 4'd0;
          end else begin
            lock_d     = 1'b1;
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
        end else begin
          lock_d     = 1'b0;
          lock_cnt_d = 4'd0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr  = sel_addr;
    bus.mem_wdata = sel_wdata;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.c_ack     = 1'b0;
    bus.d_ack     = 1'b0;
    case (state_q)
      ACCESS: begin
        if (!sel_oor) begin
          bus.mem_read  = ~sel_we;
          bus.mem_write = sel_we;
        end
      end
      RESP: begin
        if (grant_q) begin
          bus.d_ack = 1'b1;
        end else begin
          bus.c_ack = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.c_rdata = c_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mips_dmem_arbiter.sv
// tb/tb_mips_dmem_arbiter.sv - randomized self-checking bench for mips_dmem_arbiter with a transaction-level reference
// Lock scenario runs only when MIPS_DMEM_ARB_LOCK_EN is defined.
module tb_mips_dmem_arbiter;

`ifdef MIPS_DMEM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_dmem_arbiter_if bus();
  mips_dmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] dev_mem [0:255];
  logic [31:0] ref_mem [0:255];
  assign bus.mem_rdata = dev_mem[bus.mem_addr[7:0]];

  logic tb_d_lock = 1'b0;
`ifdef MIPS_DMEM_ARB_LOCK_EN
  assign bus.d_lock = tb_d_lock;
`endif

  int n_chk = 0;
  int n_err = 0;

  // stimulus state per port (0 = CPU, 1 = debug)
  bit          act [2];
  bit          rq_we [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_wdata [2];
  bit          dir [2];
  bit          dir_we [2];
  logic [31:0] dir_addr [2];
  logic [31:0] dir_wdata [2];
  int          mode = 0;  // 0 quiet, 1 random, 2 always request
  bit          rst_arm = 0;

  // reference model: one access occupies the idle cycle of grant plus two more
  int          cyc = 0;
  int          m_g_cyc = -100;
  bit          m_last = 1'b1;
  bit          m_port;
  bit          m_we;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_val;
  logic [31:0] m_crd = 32'd0;
  logic [31:0] m_drd = 32'd0;
  bit          m_err = 1'b0;
  bit          m_lock = 1'b0;
  int          m_lock_run = 0;

  int c_first = -1;
  int d_first = -1;
  bit lock_watch = 0;
  bit lock_seen_c = 0;
  bit lock_checked = 0;
  int lock_run = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return a[31:8] != 24'd0;
  endfunction

  task automatic put_req(input int p);
    if (p == 0) begin
      bus.c_req = act[0]; bus.c_we = rq_we[0]; bus.c_addr = rq_addr[0]; bus.c_wdata = rq_wdata[0];
    end else begin
      bus.d_req = act[1]; bus.d_we = rq_we[1]; bus.d_addr = rq_addr[1]; bus.d_wdata = rq_wdata[1];
    end
  endtask

  task automatic model_reset();
    m_g_cyc = -100; m_last = 1'b1; m_crd = 32'd0; m_drd = 32'd0;
    m_err = 1'b0; m_lock = 1'b0; m_lock_run = 0;
  endtask

  task automatic step();
    bit in_acc, in_resp, fresh_rst, c_ok;
    bit just [2];
    int win;
    @(negedge clk);
    cyc++;
    in_acc  = (cyc == m_g_cyc + 1);
    in_resp = (cyc == m_g_cyc + 2);
    if (in_resp) begin
      if (m_port) m_drd = m_val; else m_crd = m_val;
      if (oor(m_addr)) m_err = 1'b1;
    end
    chk("c_ack", 32'(bus.c_ack), 32'(in_resp && !m_port));
    chk("d_ack", 32'(bus.d_ack), 32'(in_resp && m_port));
    chk("mem_read", 32'(bus.mem_read), 32'(in_acc && !m_we && !oor(m_addr)));
    chk("mem_write", 32'(bus.mem_write), 32'(in_acc && m_we && !oor(m_addr)));
    chk("rw_excl", 32'(bus.mem_read && bus.mem_write), 32'd0);
    if (in_acc) chk("mem_addr", bus.mem_addr, m_addr);
    if (in_acc && m_we && !oor(m_addr)) chk("mem_wdata", bus.mem_wdata, rq_wdata[m_port]);
    chk("c_rdata", bus.c_rdata, m_crd);
    chk("d_rdata", bus.d_rdata, m_drd);
    chk("err", 32'(bus.err), 32'(m_err));

    if (bus.mem_write) dev_mem[bus.mem_addr[7:0]] = bus.mem_wdata;
    if (bus.c_ack && c_first < 0) c_first = cyc;
    if (bus.d_ack && d_first < 0) d_first = cyc;
    if (lock_watch) begin
      if (bus.d_ack) lock_run++;
      if (bus.c_ack) begin
        if (lock_seen_c && !lock_checked) begin
          chk("lock_run", 32'(lock_run), 32'd16);
          lock_checked = 1;
        end
        lock_seen_c = 1;
        lock_run = 0;
      end
    end

    // drive inputs for the next rising edge
    just[0] = 0; just[1] = 0;
    if (in_resp) begin
      act[m_port] = 0; just[m_port] = 1; put_req(m_port);
    end
    fresh_rst = rst_arm && in_acc;
    rst = fresh_rst;
    if (fresh_rst) begin
      rst_arm = 0;
      act[0] = 0; act[1] = 0; put_req(0); put_req(1);
      model_reset();
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && !just[p]) begin
          if (dir[p]) begin
            dir[p] = 0; act[p] = 1;
            rq_we[p] = dir_we[p]; rq_addr[p] = dir_addr[p]; rq_wdata[p] = dir_wdata[p];
            put_req(p);
          end else if (mode == 2 || (mode == 1 && $urandom_range(1) == 0)) begin
            act[p] = 1;
            rq_we[p] = $urandom_range(1) == 1;
            rq_addr[p] = ($urandom_range(7) == 0) ? ($urandom | 32'h100) : 32'($urandom_range(255));
            rq_wdata[p] = $urandom;
            put_req(p);
          end
        end
      end
      if (LOCK_EN && in_resp) begin
        if (m_port && tb_d_lock) begin
          m_lock_run++;
          m_lock = (m_lock_run < 16);
          if (m_lock_run == 16) m_lock_run = 0;
        end else begin
          m_lock = 0; m_lock_run = 0;
        end
      end
      // arbitration of an idle cycle, from the requests just presented
      if (cyc >= m_g_cyc + 3) begin
        c_ok = act[0] && !(LOCK_EN && m_lock);
        win = -1;
        if (c_ok && act[1]) win = m_last ? 0 : 1;
        else if (c_ok) win = 0;
        else if (act[1]) win = 1;
        if (win >= 0) begin
          m_g_cyc = cyc; m_port = win[0]; m_last = win[0];
          m_we = rq_we[win]; m_addr = rq_addr[win];
          m_val = (m_we || oor(m_addr)) ? 32'd0 : ref_mem[m_addr[7:0]];
          if (m_we && !oor(m_addr)) ref_mem[m_addr[7:0]] = rq_wdata[win];
          if (win == 0) begin m_lock = 0; m_lock_run = 0; end
        end
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    mode = 0;
    while ((act[0] || act[1] || cyc + 1 < m_g_cyc + 3) && n < 20) begin
      step();
      n++;
    end
    chk("drain", 32'(act[0] || act[1] || cyc + 1 < m_g_cyc + 3), 32'd0);
  endtask

  task automatic run(input int m, input int n);
    mode = m;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; dir[p] = 0; rq_we[p] = 0; rq_addr[p] = 0; rq_wdata[p] = 0; put_req(p);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // both ports from reset: C first, then alternation
    run(2, 12);
    chk("first_ack_gap", 32'(d_first - c_first), 32'd3);
    drain();

    // single CPU read of word 5
    dev_mem[5] = 32'h1234;
    ref_mem[5] = 32'h1234;
    dir[0] = 1; dir_we[0] = 0; dir_addr[0] = 32'd5; dir_wdata[0] = 32'd0;
    run(0, 4);
    drain();

    // out-of-range debug write
    dir[1] = 1; dir_we[1] = 1; dir_addr[1] = 32'h100; dir_wdata[1] = 32'hDEAD_BEEF;
    run(0, 4);
    drain();

    run(1, 600);
    drain();

    // reset while an access is in flight
    rst_arm = 1;
    run(2, 20);
    chk("rst_fired", 32'(rst_arm), 32'd0);
    drain();

    if (LOCK_EN) begin
      tb_d_lock = 1;
      lock_watch = 1;
      run(2, 80);
      chk("lock_seen", 32'(lock_checked), 32'd1);
      lock_watch = 0;
      tb_d_lock = 0;
      drain();
    end

    run(1, 200);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
